// File: rtl/seq_mult_param_if.sv
// Request/result bundle between an operand source, the sequential multiplier and its consumer.
// The source/consumer side uses master; the multiplier uses slave.
interface seq_mult_param_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 busy;
    logic                 out_valid;
    logic                 out_ack;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, a, b, signed_mode, out_ack,
        input  busy, out_valid, product
    );

    modport slave (
        input  start, a, b, signed_mode, out_ack,
        output busy, out_valid, product
    );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-and-add multiplier with run-time signed/unsigned mode.
// It takes WIDTH CALC cycles plus one FIX cycle, then holds the result until it is acknowledged.
module seq_mult_param #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    seq_mult_param_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PW-1:0]     mcand;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     product_r;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     cnt;
    logic              neg;

    // The most negative operand negates to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic sm);
        return (sm && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag, input logic n);
        return n ? (~mag + PW'(1)) : mag;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start)   state_nxt = CALC;
            CALC: if (cnt == LAST) state_nxt = FIX;
            FIX:                   state_nxt = DONE;
            DONE: if (bus.out_ack) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            product_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    mcand  <= {{WIDTH{1'b0}}, magnitude(bus.a, bus.signed_mode)};
                    mplier <= magnitude(bus.b, bus.signed_mode);
                    neg    <= bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    acc    <= '0;
                    cnt    <= '0;
                end
                CALC: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
                FIX:  product_r <= apply_sign(acc, neg);
                default: ;
            endcase
        end
    end

    assign bus.product = product_r;
endmodule
